// File: rtl/mem_lsu_stage.sv
// Memory-stage load/store unit: one bus access at a time via an IDLE/REQ/WAIT handshake, plus branch resolution.
// Optional feature: WIZ_LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them down.
module mem_lsu_stage #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_load,
   input  logic              i_store,
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [XLEN-1:0]   i_wdata,
   input  logic              i_branch,
   input  logic              i_jump,
   input  logic [2:0]        i_brCond,
   input  logic              i_cmpEq,
   input  logic              i_cmpLt,
   input  logic              i_cmpLtu,
   output logic              o_PCSrc,
   output logic              o_busReq,
   output logic              o_busWe,
   output logic [ADDR_W-1:0] o_busAddr,
   output logic [XLEN/8-1:0] o_busBe,
   output logic [XLEN-1:0]   o_busWdata,
   input  logic              i_busGnt,
   input  logic              i_busRvalid,
   input  logic [XLEN-1:0]   i_busRdata,
   output logic              o_done,
   output logic [XLEN-1:0]   o_readData,
   output logic              o_misaligned,
   output logic              o_busErr
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int CW   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [CW-1:0]     cnt, cnt_next;
   logic              done, done_next;
   logic              bus_err, bus_err_next;
   logic              mis, mis_next;
   logic              bus_req, bus_req_next;
   logic [XLEN-1:0]   read_data, read_data_next;
   logic              latch;

   logic [1:0]        size_eff;
   logic [2:0]        amask;
   logic [7:0]        be_mask;
   logic [ADDR_W-1:0] addr_al;
   logic [OFFW-1:0]   off_new;
   logic              accept;
   logic              mem_op;
   logic              trap;
   logic              br_take;

   logic [1:0]        size_q;
   logic              uns_q;
   logic [OFFW-1:0]   off_q;
   logic              we_q;
   logic [ADDR_W-1:0] bus_addr_q;
   logic [NB-1:0]     bus_be_q;
   logic [XLEN-1:0]   bus_wdata_q;
   logic [XLEN-1:0]   rd_shift;
   logic [63:0]       rd_ext;

   function automatic logic [63:0] extend_load(input logic [63:0] sh, input logic [1:0] size,
                                               input logic uns);
      case (size)
         2'b00:   extend_load = {{56{sh[7]  & ~uns}}, sh[7:0]};
         2'b01:   extend_load = {{48{sh[15] & ~uns}}, sh[15:0]};
         2'b10:   extend_load = {{32{sh[31] & ~uns}}, sh[31:0]};
         2'b11:   extend_load = sh;
         default: extend_load = sh;
      endcase
   endfunction

   // Size decode, alignment and lane placement of the presented operation.
   always_comb begin
      if ((XLEN == 32) && (i_size == 2'b11)) begin
         size_eff = 2'b10;
      end else begin
         size_eff = i_size;
      end
      case (size_eff)
         2'b00:   begin amask = 3'b000; be_mask = 8'h01; end
         2'b01:   begin amask = 3'b001; be_mask = 8'h03; end
         2'b10:   begin amask = 3'b011; be_mask = 8'h0F; end
         2'b11:   begin amask = 3'b111; be_mask = 8'hFF; end
         default: begin amask = 3'b000; be_mask = 8'h01; end
      endcase
      addr_al = {i_addr[ADDR_W-1:3], i_addr[2:0] & ~amask};
      off_new = addr_al[OFFW-1:0];
   end

`ifdef WIZ_LSU_MISALIGN_TRAP_EN
   assign trap = |(i_addr[2:0] & amask);
`else
   assign trap = 1'b0;
`endif

   assign accept  = i_valid & (state == IDLE);
   assign mem_op  = i_load ^ i_store;
   assign o_ready = (state == IDLE);

   // Branch condition select on RISC-V funct3; 010/011 never take.
   always_comb begin
      case (i_brCond)
         3'b000:  br_take = i_cmpEq;
         3'b001:  br_take = ~i_cmpEq;
         3'b100:  br_take = i_cmpLt;
         3'b101:  br_take = ~i_cmpLt;
         3'b110:  br_take = i_cmpLtu;
         3'b111:  br_take = ~i_cmpLtu;
         default: br_take = 1'b0;
      endcase
   end

   assign o_PCSrc = accept & (i_jump | (i_branch & br_take));

   assign rd_shift = i_busRdata >> {off_q, 3'b000};
   assign rd_ext   = extend_load(64'(rd_shift), size_q, uns_q);

   // Next-state and registered-output decode for the bus handshake.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      done_next      = 1'b0;
      bus_err_next   = 1'b0;
      mis_next       = 1'b0;
      bus_req_next   = bus_req;
      read_data_next = read_data;
      latch          = 1'b0;
      case (state)
         IDLE: begin
            if (accept && mem_op && trap) begin
               done_next = 1'b1;
               mis_next  = 1'b1;
            end else if (accept && mem_op) begin
               latch        = 1'b1;
               bus_req_next = 1'b1;
               state_next   = REQ;
            end else if (accept) begin
               done_next = 1'b1;
            end else begin
               bus_req_next = 1'b0;
            end
         end
         REQ: begin
            if (i_busGnt && we_q) begin
               bus_req_next = 1'b0;
               done_next    = 1'b1;
               state_next   = IDLE;
            end else if (i_busGnt) begin
               bus_req_next = 1'b0;
               cnt_next     = {CW{1'b0}};
               state_next   = WAIT;
            end else begin
               bus_req_next = 1'b1;
            end
         end
         WAIT: begin
            if (i_busRvalid) begin
               read_data_next = XLEN'(rd_ext);
               done_next      = 1'b1;
               state_next     = IDLE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               bus_err_next = 1'b1;
               done_next    = 1'b1;
               state_next   = IDLE;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: begin
            bus_req_next = 1'b0;
            state_next   = IDLE;
         end
      endcase
   end

   // Control state and pulse outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= IDLE;
         cnt       <= {CW{1'b0}};
         done      <= 1'b0;
         bus_err   <= 1'b0;
         mis       <= 1'b0;
         bus_req   <= 1'b0;
         read_data <= {XLEN{1'b0}};
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         done      <= done_next;
         bus_err   <= bus_err_next;
         mis       <= mis_next;
         bus_req   <= bus_req_next;
         read_data <= read_data_next;
      end
   end

   // Request fields captured at accept and held stable until the grant.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         off_q       <= {OFFW{1'b0}};
         we_q        <= 1'b0;
         bus_addr_q  <= {ADDR_W{1'b0}};
         bus_be_q    <= {NB{1'b0}};
         bus_wdata_q <= {XLEN{1'b0}};
      end else if (latch) begin
         size_q      <= size_eff;
         uns_q       <= i_unsigned;
         off_q       <= off_new;
         we_q        <= i_store;
         bus_addr_q  <= {addr_al[ADDR_W-1:OFFW], {OFFW{1'b0}}};
         bus_be_q    <= NB'(be_mask) << off_new;
         bus_wdata_q <= i_wdata << {off_new, 3'b000};
      end else begin
         size_q      <= size_q;
         uns_q       <= uns_q;
         off_q       <= off_q;
         we_q        <= we_q;
         bus_addr_q  <= bus_addr_q;
         bus_be_q    <= bus_be_q;
         bus_wdata_q <= bus_wdata_q;
      end
   end

   assign o_busReq     = bus_req;
   assign o_busWe      = we_q & bus_req;
   assign o_busAddr    = bus_addr_q;
   assign o_busBe      = bus_be_q;
   assign o_busWdata   = bus_wdata_q;
   assign o_done       = done;
   assign o_readData   = read_data;
   assign o_misaligned = mis;
   assign o_busErr     = bus_err;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage (XLEN=32, TIMEOUT=4) with a completion scoreboard.
module tb_mem_lsu_stage;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_valid, o_ready, i_load, i_store, i_unsigned;
   logic [1:0]  i_size;
   logic [31:0] i_addr, i_wdata;
   logic        i_branch, i_jump, i_cmpEq, i_cmpLt, i_cmpLtu;
   logic [2:0]  i_brCond;
   logic        o_PCSrc, o_busReq, o_busWe;
   logic [31:0] o_busAddr, o_busWdata;
   logic [3:0]  o_busBe;
   logic        i_busGnt, i_busRvalid;
   logic [31:0] i_busRdata;
   logic        o_done, o_misaligned, o_busErr;
   logic [31:0] o_readData;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic        err;
      logic        mis;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   mem_lsu_stage #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_load(i_load), .i_store(i_store), .i_size(i_size), .i_unsigned(i_unsigned),
      .i_addr(i_addr), .i_wdata(i_wdata), .i_branch(i_branch), .i_jump(i_jump),
      .i_brCond(i_brCond), .i_cmpEq(i_cmpEq), .i_cmpLt(i_cmpLt), .i_cmpLtu(i_cmpLtu),
      .o_PCSrc(o_PCSrc), .o_busReq(o_busReq), .o_busWe(o_busWe), .o_busAddr(o_busAddr),
      .o_busBe(o_busBe), .o_busWdata(o_busWdata), .i_busGnt(i_busGnt),
      .i_busRvalid(i_busRvalid), .i_busRdata(i_busRdata), .o_done(o_done),
      .o_readData(o_readData), .o_misaligned(o_misaligned), .o_busErr(o_busErr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string tag, input logic [31:0] data, input logic err, input logic mis);
      exp_t e;
      e.tag  = tag;
      e.data = data;
      e.err  = err;
      e.mis  = mis;
      sb.push_back(e);
   endtask

   task automatic expect_done(input string tag);
      exp_t e;
      chk({tag, " done"}, 64'(o_done), 64'd1);
      if (o_done === 1'b1) begin
         chk({tag, " sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, " readData"}, 64'(o_readData), 64'(e.data));
            chk({e.tag, " busErr"}, 64'(o_busErr), 64'(e.err));
            chk({e.tag, " misaligned"}, 64'(o_misaligned), 64'(e.mis));
         end
      end
   endtask

   task automatic drive_mem(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd);
      i_valid    = 1'b1;
      i_load     = ld;
      i_store    = st;
      i_size     = sz;
      i_unsigned = uns;
      i_addr     = addr;
      i_wdata    = wd;
   endtask

   task automatic clear_op();
      i_valid = 1'b0;
      i_load  = 1'b0;
      i_store = 1'b0;
   endtask

   initial begin
      i_reset = 1'b1; i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0; i_size = 2'b00;
      i_unsigned = 1'b0; i_addr = 32'h0; i_wdata = 32'h0; i_branch = 1'b0; i_jump = 1'b0;
      i_brCond = 3'b000; i_cmpEq = 1'b0; i_cmpLt = 1'b0; i_cmpLtu = 1'b0;
      i_busGnt = 1'b0; i_busRvalid = 1'b0; i_busRdata = 32'h0;
      repeat (2) step();
      chk("rst ready", 64'(o_ready), 64'd1);
      chk("rst busReq", 64'(o_busReq), 64'd0);
      chk("rst done", 64'(o_done), 64'd0);
      chk("rst readData", 64'(o_readData), 64'd0);
      chk("rst busErr", 64'(o_busErr), 64'd0);
      chk("rst misaligned", 64'(o_misaligned), 64'd0);
      chk("rst busBe", 64'(o_busBe), 64'd0);
      i_reset = 1'b0;
      step();

      // Branch resolution: all within one cycle, deasserted before the next edge.
      i_valid = 1'b1; i_branch = 1'b1; i_brCond = 3'b001; i_cmpEq = 1'b0;
      #1 chk("bne taken", 64'(o_PCSrc), 64'd1);
      i_brCond = 3'b110; i_cmpLtu = 1'b0;
      #1 chk("bltu not taken", 64'(o_PCSrc), 64'd0);
      i_brCond = 3'b101; i_cmpLt = 1'b0;
      #1 chk("bge taken", 64'(o_PCSrc), 64'd1);
      i_brCond = 3'b010; i_cmpEq = 1'b1;
      #1 chk("brcond 010", 64'(o_PCSrc), 64'd0);
      i_branch = 1'b0; i_jump = 1'b1;
      #1 chk("jump", 64'(o_PCSrc), 64'd1);
      i_valid = 1'b0;
      #1 chk("jump no valid", 64'(o_PCSrc), 64'd0);
      i_jump = 1'b0;
      step();
      chk("no accept done", 64'(o_done), 64'd0);

      // Signed byte load, zero-wait, rvalid alongside grant must be ignored.
      push_exp("lb", 32'hFFFF_FF80, 1'b0, 1'b0);
      drive_mem(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0);
      step();
      clear_op();
      chk("lb busReq", 64'(o_busReq), 64'd1);
      chk("lb busBe", 64'(o_busBe), 64'h8);
      chk("lb busAddr", 64'(o_busAddr), 64'h1000);
      chk("lb busWe", 64'(o_busWe), 64'd0);
      chk("lb ready busy", 64'(o_ready), 64'd0);
      i_valid = 1'b1; i_jump = 1'b1;
      #1 chk("jump while busy", 64'(o_PCSrc), 64'd0);
      i_valid = 1'b0; i_jump = 1'b0;
      i_busGnt = 1'b1; i_busRvalid = 1'b1; i_busRdata = 32'h5555_5555;
      step();
      chk("lb no early done", 64'(o_done), 64'd0);
      i_busGnt = 1'b0; i_busRvalid = 1'b1; i_busRdata = 32'h80FF_FF00;
      step();
      i_busRvalid = 1'b0;
      expect_done("lb");
      step();
      chk("lb done pulse", 64'(o_done), 64'd0);

      // Byte store, then a jump accepted in the same cycle as its o_done.
      push_exp("sb", 32'hFFFF_FF80, 1'b0, 1'b0);
      drive_mem(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h0000_00AB);
      step();
      clear_op();
      chk("sb busReq", 64'(o_busReq), 64'd1);
      chk("sb busWe", 64'(o_busWe), 64'd1);
      chk("sb busBe", 64'(o_busBe), 64'h2);
      chk("sb busWdata lane", 64'(o_busWdata[15:8]), 64'hAB);
      chk("sb busAddr", 64'(o_busAddr), 64'h3000);
      i_busGnt = 1'b1;
      step();
      i_busGnt = 1'b0;
      expect_done("sb");
      chk("sb ready at done", 64'(o_ready), 64'd1);
      push_exp("jal", 32'hFFFF_FF80, 1'b0, 1'b0);
      i_valid = 1'b1; i_jump = 1'b1;
      #1 chk("jal accept pcsrc", 64'(o_PCSrc), 64'd1);
      step();
      i_valid = 1'b0; i_jump = 1'b0;
      expect_done("jal");
      chk("jal no bus", 64'(o_busReq), 64'd0);
      step();

      // Unsigned half load with grant delayed three cycles.
      push_exp("lhu", 32'h0000_BEEF, 1'b0, 1'b0);
      drive_mem(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0);
      step();
      clear_op();
      for (int k = 0; k < 3; k++) begin
         chk("lhu req held", 64'(o_busReq), 64'd1);
         chk("lhu busBe", 64'(o_busBe), 64'hC);
         step();
      end
      chk("lhu req at grant", 64'(o_busReq), 64'd1);
      i_busGnt = 1'b1;
      step();
      i_busGnt = 1'b0; i_busRvalid = 1'b1; i_busRdata = 32'hBEEF_1234;
      step();
      i_busRvalid = 1'b0;
      expect_done("lhu");
      step();

      // Timeout: granted load with no rvalid.
      push_exp("tmo", 32'h0000_BEEF, 1'b1, 1'b0);
      drive_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
      step();
      clear_op();
      i_busGnt = 1'b1;
      step();
      i_busGnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("tmo waiting done", 64'(o_done), 64'd0);
         chk("tmo waiting err", 64'(o_busErr), 64'd0);
         step();
      end
      expect_done("tmo");
      step();
      chk("tmo err pulse", 64'(o_busErr), 64'd0);

      // Misaligned word load.
`ifdef WIZ_LSU_MISALIGN_TRAP_EN
      push_exp("mis", 32'h0000_BEEF, 1'b0, 1'b1);
      drive_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0);
      step();
      clear_op();
      chk("mis no busReq", 64'(o_busReq), 64'd0);
      expect_done("mis");
      step();
`else
      push_exp("mis", 32'h1234_5678, 1'b0, 1'b0);
      drive_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0);
      step();
      clear_op();
      chk("mis busAddr", 64'(o_busAddr), 64'h1000);
      chk("mis busBe", 64'(o_busBe), 64'hF);
      chk("mis busReq", 64'(o_busReq), 64'd1);
      i_busGnt = 1'b1;
      step();
      i_busGnt = 1'b0; i_busRvalid = 1'b1; i_busRdata = 32'h1234_5678;
      step();
      i_busRvalid = 1'b0;
      expect_done("mis");
      step();
`endif

      // Reset in WAIT abandons the access without a completion.
      drive_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
      step();
      clear_op();
      i_busGnt = 1'b1;
      step();
      i_busGnt = 1'b0;
      chk("wait not ready", 64'(o_ready), 64'd0);
      i_reset = 1'b1;
      #1;
      chk("mid rst ready", 64'(o_ready), 64'd1);
      chk("mid rst busReq", 64'(o_busReq), 64'd0);
      chk("mid rst done", 64'(o_done), 64'd0);
      chk("mid rst readData", 64'(o_readData), 64'd0);
      step();
      i_reset = 1'b0;
      i_busRvalid = 1'b1; i_busRdata = 32'hDEAD_BEEF;
      step();
      chk("post rst no done", 64'(o_done), 64'd0);
      i_busRvalid = 1'b0;
      step();
      chk("post rst idle done", 64'(o_done), 64'd0);
      chk("post rst readData", 64'(o_readData), 64'd0);
      chk("scoreboard drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
